io_bus_arbiter: RTL and testbench

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

---
 rtl/io_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_io_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single io slave.
// Optional ack timeout is enabled by defining IO_BUS_ARBITER_TIMEOUT_EN.
module io_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        system_clock,
    input  logic        hardware_reset_n,
    input  logic [27:0] m0_addr,
    input  logic [31:0] m0_data_in,
    output logic [31:0] m0_data_out,
    input  logic [3:0]  m0_data_sel,
    input  logic        m0_write,
    input  logic        m0_ready,
    output logic        m0_ack,
    input  logic [27:0] m1_addr,
    input  logic [31:0] m1_data_in,
    output logic [31:0] m1_data_out,
    input  logic [3:0]  m1_data_sel,
    input  logic        m1_write,
    input  logic        m1_ready,
    output logic        m1_ack,
    output logic [27:0] s_addr,
    output logic [31:0] s_data_out,
    output logic [3:0]  s_data_sel,
    output logic        s_write,
    output logic        s_ready,
    input  logic [31:0] s_data_in,
    input  logic        s_ack,
    output logic [1:0]  grant,
    output logic        arb_timeout
);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StRelease} state_e;

    state_e state_q, state_d;
    logic   rr_q, rr_d;  // master granted last; reset value 1 lets master 0 win the first tie
    logic   timeout_hit;
    logic   in_grant;
    logic   owner_ready;

    assign in_grant    = (state_q == StGrant0) || (state_q == StGrant1);
    assign owner_ready = (state_q == StGrant1) ? m1_ready : m0_ready;

`ifdef IO_BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            flag_q, flag_d;

    assign timeout_hit = in_grant && (cnt_q == CntW'(TIMEOUT_CYCLES));
    assign arb_timeout = flag_q | timeout_hit;

    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q | timeout_hit;
        if (state_q == StIdle && state_d != StIdle) begin
            cnt_d = '0;
        end else if (in_grant && owner_ready && !s_ack && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge system_clock or negedge hardware_reset_n) begin
        if (!hardware_reset_n) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
    assign arb_timeout        = 1'b0;
`endif

    always_ff @(posedge system_clock or negedge hardware_reset_n) begin
        if (!hardware_reset_n) begin
            state_q <= StIdle;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (!s_ack) begin
                    if (m0_ready && m1_ready) begin
                        state_d = rr_q ? StGrant0 : StGrant1;
                    end else if (m0_ready) begin
                        state_d = StGrant0;
                    end else if (m1_ready) begin
                        state_d = StGrant1;
                    end
                end
                if (state_d == StGrant0) rr_d = 1'b0;
                if (state_d == StGrant1) rr_d = 1'b1;
            end
            StGrant0, StGrant1: begin
                if (timeout_hit || !owner_ready) state_d = StRelease;
            end
            StRelease: begin
                // Wait out any lingering ack so it cannot leak to the next owner.
                if (!s_ack) state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        grant       = 2'b00;
        s_addr      = '0;
        s_data_out  = '0;
        s_data_sel  = '0;
        s_write     = 1'b0;
        s_ready     = 1'b0;
        m0_ack      = 1'b0;
        m0_data_out = '0;
        m1_ack      = 1'b0;
        m1_data_out = '0;
        unique case (state_q)
            StGrant0: begin
                grant       = 2'b01;
                s_addr      = m0_addr;
                s_data_out  = m0_data_in;
                s_data_sel  = m0_data_sel;
                s_write     = m0_write;
                s_ready     = m0_ready & ~timeout_hit;
                m0_ack      = s_ack | timeout_hit;
                m0_data_out = timeout_hit ? 32'hFFFF_FFFF : s_data_in;
            end
            StGrant1: begin
                grant       = 2'b10;
                s_addr      = m1_addr;
                s_data_out  = m1_data_in;
                s_data_sel  = m1_data_sel;
                s_write     = m1_write;
                s_ready     = m1_ready & ~timeout_hit;
                m1_ack      = s_ack | timeout_hit;
                m1_data_out = timeout_hit ? 32'hFFFF_FFFF : s_data_in;
            end
            StIdle, StRelease: ;
        endcase
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter with hand-computed expectations.
// Define IO_BUS_ARBITER_TIMEOUT_EN to exercise the timeout path.
module tb_io_bus_arbiter;

    logic        system_clock = 1'b0;
    logic        hardware_reset_n;
    logic [27:0] m0_addr, m1_addr, s_addr;
    logic [31:0] m0_data_in, m1_data_in, m0_data_out, m1_data_out;
    logic [31:0] s_data_out, s_data_in;
    logic [3:0]  m0_data_sel, m1_data_sel, s_data_sel;
    logic        m0_write, m1_write, s_write;
    logic        m0_ready, m1_ready, s_ready;
    logic        m0_ack, m1_ack, s_ack;
    logic [1:0]  grant;
    logic        arb_timeout;

    int checks = 0;
    int errors = 0;

    always #5 system_clock = ~system_clock;

    io_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .system_clock    (system_clock),
        .hardware_reset_n(hardware_reset_n),
        .m0_addr         (m0_addr),
        .m0_data_in      (m0_data_in),
        .m0_data_out     (m0_data_out),
        .m0_data_sel     (m0_data_sel),
        .m0_write        (m0_write),
        .m0_ready        (m0_ready),
        .m0_ack          (m0_ack),
        .m1_addr         (m1_addr),
        .m1_data_in      (m1_data_in),
        .m1_data_out     (m1_data_out),
        .m1_data_sel     (m1_data_sel),
        .m1_write        (m1_write),
        .m1_ready        (m1_ready),
        .m1_ack          (m1_ack),
        .s_addr          (s_addr),
        .s_data_out      (s_data_out),
        .s_data_sel      (s_data_sel),
        .s_write         (s_write),
        .s_ready         (s_ready),
        .s_data_in       (s_data_in),
        .s_ack           (s_ack),
        .grant           (grant),
        .arb_timeout     (arb_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge system_clock);
        #2;
    endtask

    task automatic do_reset();
        hardware_reset_n = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        s_ack    = 1'b0;
        tick();
        hardware_reset_n = 1'b1;
        tick();
    endtask

    initial begin
        m0_addr = '0; m1_addr = '0; m0_data_in = 32'hA0A0_0000; m1_data_in = 32'hB1B1_0000;
        m0_data_sel = 4'hF; m1_data_sel = 4'h3; m0_write = 1'b0; m1_write = 1'b1;
        s_data_in = '0;
        hardware_reset_n = 1'b0;
        m0_ready = 1'b0; m1_ready = 1'b0; s_ack = 1'b0;
        #3;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_s_ready", 32'(s_ready), 32'h0);
        check_eq("rst_timeout", 32'(arb_timeout), 32'h0);
        do_reset();

        // Single master-0 read
        m0_addr = 28'h4; m0_ready = 1'b1; s_data_in = 32'h1234_5678;
        #1;
        check_eq("rd_s_ready_pre", 32'(s_ready), 32'h0);
        tick();
        check_eq("rd_grant", 32'(grant), 32'h1);
        check_eq("rd_s_ready", 32'(s_ready), 32'h1);
        check_eq("rd_s_addr", 32'(s_addr), 32'h4);
        check_eq("rd_s_sel", 32'(s_data_sel), 32'hF);
        s_ack = 1'b1;
        #1;
        check_eq("rd_m0_ack", 32'(m0_ack), 32'h1);
        check_eq("rd_m0_data", m0_data_out, 32'h1234_5678);
        check_eq("rd_m1_ack", 32'(m1_ack), 32'h0);
        check_eq("rd_m1_data", m1_data_out, 32'h0);
        tick();
        m0_ready = 1'b0; s_ack = 1'b0;
        tick();
        check_eq("rd_release_grant", 32'(grant), 32'h0);
        check_eq("rd_release_sready", 32'(s_ready), 32'h0);
        tick();

        // Tie after reset: 01, 10, 01
        do_reset();
        m0_ready = 1'b1; m1_ready = 1'b1;
        tick();
        check_eq("tie1_grant", 32'(grant), 32'h1);
        s_ack = 1'b1;
        #1;
        check_eq("tie1_m0_ack", 32'(m0_ack), 32'h1);
        check_eq("tie1_m1_ack", 32'(m1_ack), 32'h0);
        tick();
        m0_ready = 1'b0; s_ack = 1'b0;
        tick();
        check_eq("tie1_release", 32'(grant), 32'h0);
        tick();
        check_eq("tie1_idle", 32'(grant), 32'h0);
        tick();
        check_eq("tie2_grant", 32'(grant), 32'h2);
        check_eq("tie2_s_write", 32'(s_write), 32'h1);
        s_ack = 1'b1;
        #1;
        check_eq("tie2_m1_ack", 32'(m1_ack), 32'h1);
        check_eq("tie2_m0_ack", 32'(m0_ack), 32'h0);
        tick();
        m1_ready = 1'b0; s_ack = 1'b0;
        tick();
        m0_ready = 1'b1; m1_ready = 1'b1;
        tick();
        tick();
        check_eq("tie3_grant", 32'(grant), 32'h1);

        // Stale ack held for 3 cycles while master 1 waits
        s_ack = 1'b1;
        tick();
        m0_ready = 1'b0;
        #1;
        check_eq("stale_m1_ack0", 32'(m1_ack), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stale_grant", 32'(grant), 32'h0);
            check_eq("stale_m1_ack", 32'(m1_ack), 32'h0);
        end
        s_ack = 1'b0;
        tick();
        check_eq("stale_idle", 32'(grant), 32'h0);
        tick();
        check_eq("stale_g1", 32'(grant), 32'h2);
        check_eq("stale_g1_ack", 32'(m1_ack), 32'h0);

        // Asynchronous reset during GRANT1
        s_ack = 1'b1;
        #1;
        check_eq("arst_pre_ack", 32'(m1_ack), 32'h1);
        hardware_reset_n = 1'b0;
        #1;
        check_eq("arst_s_ready", 32'(s_ready), 32'h0);
        check_eq("arst_grant", 32'(grant), 32'h0);
        check_eq("arst_m1_ack", 32'(m1_ack), 32'h0);
        m1_ready = 1'b0; s_ack = 1'b0;
        tick();
        hardware_reset_n = 1'b1;
        m0_ready = 1'b1;
        tick();
        check_eq("arst_idle_g0", 32'(grant), 32'h1);
        m0_ready = 1'b0;
        tick();
        tick();

        // One-cycle master-1 pulse with no ack
        m1_ready = 1'b1;
        tick();
        check_eq("pulse_grant", 32'(grant), 32'h2);
        m1_ready = 1'b0;
        #1;
        check_eq("pulse_ack", 32'(m1_ack), 32'h0);
        tick();
        check_eq("pulse_release", 32'(grant), 32'h0);
        check_eq("pulse_rel_ack", 32'(m1_ack), 32'h0);
        m0_ready = 1'b1;
        tick();
        check_eq("pulse_idle", 32'(grant), 32'h0);
        tick();
        check_eq("pulse_next_g0", 32'(grant), 32'h1);

        // Slave never acks
        do_reset();
        m0_ready = 1'b1;
        tick();
`ifdef IO_BUS_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check_eq("to_pre_ack", 32'(m0_ack), 32'h0);
        check_eq("to_pre_flag", 32'(arb_timeout), 32'h0);
        tick();
        check_eq("to_ack", 32'(m0_ack), 32'h1);
        check_eq("to_data", m0_data_out, 32'hFFFF_FFFF);
        check_eq("to_s_ready", 32'(s_ready), 32'h0);
        check_eq("to_flag", 32'(arb_timeout), 32'h1);
        m0_ready = 1'b0;
        tick();
        check_eq("to_release", 32'(grant), 32'h0);
        tick();
        tick();
        check_eq("to_sticky", 32'(arb_timeout), 32'h1);
        do_reset();
        check_eq("to_cleared", 32'(arb_timeout), 32'h0);
`else
        for (int i = 0; i < 40; i++) tick();
        check_eq("wait_grant", 32'(grant), 32'h1);
        check_eq("wait_s_ready", 32'(s_ready), 32'h1);
        check_eq("wait_ack", 32'(m0_ack), 32'h0);
        check_eq("wait_flag", 32'(arb_timeout), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
